ram_burst_writer_32bit: RTL
===========================

RAM_BURST_WRITER_32BIT -- requirements
Module: ram_burst_writer_32bit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning address width; depth is 2**ADDR_W (32 words).
REQ-003 SHALL have port CLK  input  1  rising-edge clock; the only clock.
REQ-004 SHALL have port RST_N  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  burst request, sampled only in IDLE.
REQ-006 SHALL have port base_addr  input  ADDR_W  first write address, captured with start.
REQ-007 SHALL have port len  input  ADDR_W+1  burst length in words, captured with start.
REQ-008 SHALL have port wr_valid  input  1  write word present on wr_data.
REQ-009 SHALL have port wr_data  input  DATA_W  write word.
REQ-010 SHALL have port wr_ready  output  1  block accepts a word this cycle.
REQ-011 SHALL have port busy  output  1  burst in progress.
REQ-012 SHALL have port done  output  1  one-cycle pulse at burst end.
REQ-013 SHALL have port wr_count  output  ADDR_W+1  words written in the current or last burst.
REQ-014 SHALL have port address  input  ADDR_W  read address.
REQ-015 SHALL have port out  output  DATA_W  registered read data.

Function
REQ-016 SHALL implement FSM states IDLE, WRITE, DONE; IDLE->WRITE on start with len>0; IDLE->DONE on start with len==0; WRITE->DONE when the last word is accepted; DONE->IDLE unconditionally after one cycle.
REQ-017 SHALL clamp captured len greater than 2**ADDR_W to 2**ADDR_W.
REQ-018 SHALL assert wr_ready only in WRITE; a word is accepted when wr_valid and wr_ready are both high at a rising CLK edge.
REQ-019 SHALL write an accepted word to mem[ptr] at that edge, then increment ptr modulo 2**ADDR_W (wrap 31->0) and increment wr_count.
REQ-020 SHALL hold ptr and wr_count while wr_valid is low in WRITE (stalls of any length allowed).
REQ-021 SHALL assert busy in WRITE and DONE; busy low in IDLE.
REQ-022 SHALL pulse done high for exactly the one cycle spent in DONE.
REQ-023 SHALL ignore start in WRITE and DONE; no recapture of base_addr/len.
REQ-024 SHALL clear wr_count to 0 on entering WRITE or DONE from IDLE; hold it in IDLE until the next start.
REQ-025 SHALL update out on every rising CLK edge to mem[address] (one-cycle read latency), independent of FSM state.
REQ-026 SHALL return old data on out when address equals the write address in the same cycle (read-before-write).
REQ-027 SHALL accept the final word and assert done on consecutive cycles: last accept at edge N, done high for the cycle after edge N.

Reset
REQ-028 SHALL on RST_N low immediately force state IDLE, wr_ready 0, busy 0, done 0, wr_count 0, out 0, ptr 0.
REQ-029 SHALL NOT reset memory contents; words written before reset remain readable.
REQ-030 SHALL abandon a burst interrupted by reset; words already accepted stay written, no done pulse is issued.

Structure
REQ-031 SHALL place DATA_W, ADDR_W defaults and the FSM state encoding in a shared package ram_pkg.
REQ-032 SHALL instantiate one sub-module ram_core_32bit (storage array, one write port, one registered read port); FSM and counters live in the top.

Verification
REQ-033 Reset then start with base_addr=0, len=4, wr_data 0xA0..0xA3 back-to-back -> four accepts on consecutive cycles, done one cycle after the 4th accept, reads of 0..3 give 0xA0..0xA3 one cycle after address.
REQ-034 base_addr=30, len=4, data 0x11..0x14 -> mem[30]=0x11, mem[31]=0x12, mem[0]=0x13, mem[1]=0x14; wr_count=4.
REQ-035 len=3 with wr_valid low for 5 cycles between words -> ptr and wr_count hold during stall, done only after the 3rd accept.
REQ-036 len=0 -> no write, done pulses one cycle after start, wr_count=0; len=40 -> exactly 32 writes.
REQ-037 start asserted mid-burst with different base_addr -> ignored, original burst completes unchanged.
REQ-038 RST_N low after 2 of 5 words -> outputs at reset values immediately, no done pulse, first 2 words readable after release.

Source files
------------

// File: rtl/ram_pkg.sv
// ram_pkg: shared defaults and FSM state encoding for the burst-writer RAM.
//   RAM_DATA_W : default word width in bits
//   RAM_ADDR_W : default address width (depth = 2**RAM_ADDR_W)
//   state_t    : burst FSM states
package ram_pkg;

  localparam int RAM_DATA_W = 32;
  localparam int RAM_ADDR_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/ram_core_32bit.sv
// ram_core_32bit: storage array with one synchronous write port and one
// registered read port.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (read register only)
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data, one cycle after raddr
module ram_core_32bit
  import ram_pkg::*;
#(
  parameter int DATA_W = RAM_DATA_W,
  parameter int ADDR_W = RAM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto RAM macros and keeps its
  // contents across a reset of the control logic.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // NOTE: non-blocking updates mean a read of the address being written in
  // the same cycle returns the old word (read-before-write).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/ram_burst_writer_32bit.sv
// ram_burst_writer_32bit: writes a burst of len words into a RAM starting at
// base_addr (wrapping at the top of the array), with an independent
// registered read port.
//   CLK       : rising-edge clock
//   RST_N     : asynchronous active-low reset
//   start     : burst request, sampled only in IDLE
//   base_addr : first write address, captured with start
//   len       : burst length in words, captured with start (clamped to depth)
//   wr_valid  : write word present on wr_data
//   wr_data   : write word
//   wr_ready  : block accepts a word this cycle
//   busy      : burst in progress (WRITE or DONE)
//   done      : one-cycle pulse at burst end
//   wr_count  : words written in the current or last burst
//   address   : read address
//   out       : registered read data, one cycle after address
module ram_burst_writer_32bit
  import ram_pkg::*;
#(
  parameter int DATA_W = RAM_DATA_W,
  parameter int ADDR_W = RAM_ADDR_W
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   wr_count,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] out
);

  localparam logic [ADDR_W:0]   DEPTH   = (ADDR_W + 1)'(2 ** ADDR_W);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   len_clamped;
  logic              accept;
  logic              last_word;

  assign len_clamped = (len > DEPTH) ? DEPTH : len;
  assign accept      = wr_valid && wr_ready;
  assign last_word   = (wr_count + CNT_ONE) == len_q;

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_next = state;
    wr_ready   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = (len == '0) ? ST_DONE : ST_WRITE;
        end
      end
      ST_WRITE: begin
        wr_ready = 1'b1;
        busy     = 1'b1;
        if (wr_valid && last_word) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      len_q    <= '0;
      wr_count <= '0;
    end else begin
      state <= state_next;
      unique case (state)
        ST_IDLE: begin
          // Burst parameters are captured only here, so start is ignored
          // for the rest of the burst.
          if (start) begin
            ptr      <= base_addr;
            len_q    <= len_clamped;
            wr_count <= '0;
          end
        end
        ST_WRITE: begin
          if (accept) begin
            ptr      <= ptr + PTR_ONE;  // wraps naturally at the top
            wr_count <= wr_count + CNT_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  ram_core_32bit #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_core (
    .clk   (CLK),
    .rst_n (RST_N),
    .we    (accept),
    .waddr (ptr),
    .wdata (wr_data),
    .raddr (address),
    .rdata (out)
  );

endmodule
